// File: rtl/xgmii_pkg.sv
// Shared XGMII definitions: control characters, lane typedefs and a lane
// classification helper used by the receive aligner.
package xgmii_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;

  typedef logic [7:0] lane_byte_t;
  typedef logic       lane_ctl_t;

  // True when a lane carries the given control character.
  function automatic logic is_char(input lane_byte_t d, input lane_ctl_t c,
                                   input lane_byte_t ch);
    return c && (d == ch);
  endfunction

endpackage

// File: rtl/xgmii_lane_mux.sv
// Combinational byte-lane selector. Output lane j takes lane j+shift of the
// older word (b) while that index stays inside the word, and otherwise wraps
// into the newer word (a). Data and control are steered identically.
module xgmii_lane_mux
  import xgmii_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [8*LANES-1:0]         a_d,
  input  logic [LANES-1:0]           a_c,
  input  logic [8*LANES-1:0]         b_d,
  input  logic [LANES-1:0]           b_c,
  input  logic [$clog2(LANES)-1:0]   shift,
  output logic [8*LANES-1:0]         d,
  output logic [LANES-1:0]           c
);

  // Select each output lane from b (low side) or a (high side).
  always_comb begin
    d = '0;
    c = '0;
    for (int j = 0; j < LANES; j++) begin
      int idx;
      idx = j + int'(shift);
      if (idx < LANES) begin
        d[8*j +: 8] = b_d[8*idx +: 8];
        c[j]        = b_c[idx];
      end else begin
        d[8*j +: 8] = a_d[8*(idx-LANES) +: 8];
        c[j]        = a_c[idx-LANES];
      end
    end
  end

endmodule

// File: rtl/xgmiialign.sv
// XGMII receive start-of-frame aligner. Two word registers (A newest, B older)
// feed a lane mux so every accepted /S/ leaves in lane 0. The shift register
// and its previous value together describe a transition: on the first output
// built after a shift change, lanes that would repeat are idle-filled and
// lanes that are skipped are checked for non-idle content.
// A misaligned /S/ is reported on the first output built with its word in A.
module xgmiialign
  import xgmii_pkg::*;
#(
  parameter int         LANES      = 8,
  parameter int         ALIGN      = 4,
  parameter logic [7:0] START_CHAR = XGMII_START,
  parameter logic [7:0] IDLE_CHAR  = XGMII_IDLE
) (
  input  logic                       xgmii_rx_clk,
  input  logic                       sys_rst,
  input  logic [8*LANES-1:0]         xgmii_rxd_i,
  input  logic [LANES-1:0]           xgmii_rxc_i,
  output logic [8*LANES-1:0]         xgmii_rxd_o,
  output logic [LANES-1:0]           xgmii_rxc_o,
  output logic [$clog2(LANES)-1:0]   lane_shift,
  output logic                       err_misalign,
  output logic                       err_drop,
  output logic [31:0]                start_cnt
);

  localparam int SW = $clog2(LANES);

  logic [8*LANES-1:0] a_d, b_d, mux_d, fill_d;
  logic [LANES-1:0]   a_c, b_c, mux_c, fill_c;
  logic [SW-1:0]      shift_prev;
  logic [SW-1:0]      start_lane;
  logic               start_found;
  logic               start_illegal;
  logic               mis_pend;
  logic               drop_now;
  logic [31:0]        cnt_q;

  assign start_cnt = cnt_q;

  xgmii_lane_mux #(.LANES(LANES)) u_mux (
    .a_d   (a_d),
    .a_c   (a_c),
    .b_d   (b_d),
    .b_c   (b_c),
    .shift (lane_shift),
    .d     (mux_d),
    .c     (mux_c)
  );

  // Find the lowest legal /S/ lane in the incoming word; note misplaced ones.
  always_comb begin
    start_found   = 1'b0;
    start_lane    = '0;
    start_illegal = 1'b0;
    for (int p = 0; p < LANES; p++) begin
      if (is_char(xgmii_rxd_i[8*p +: 8], xgmii_rxc_i[p], START_CHAR)) begin
        if ((p % ALIGN) == 0) begin
          if (!start_found) begin
            start_found = 1'b1;
            start_lane  = SW'(p);
          end
        end else begin
          start_illegal = 1'b1;
        end
      end
    end
  end

  // Transition handling: idle-fill repeated lanes, flag skipped non-idle lanes.
  always_comb begin
    fill_d   = mux_d;
    fill_c   = mux_c;
    drop_now = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if ((int'(shift_prev) > int'(lane_shift)) &&
          (j < int'(shift_prev) - int'(lane_shift))) begin
        fill_d[8*j +: 8] = IDLE_CHAR;
        fill_c[j]        = 1'b1;
      end
      if ((j >= int'(shift_prev)) && (j < int'(lane_shift)) &&
          !is_char(b_d[8*j +: 8], b_c[j], IDLE_CHAR)) begin
        drop_now = 1'b1;
      end
    end
  end

  // Word pipeline, shift tracking, flags, start counter and output register.
  always_ff @(posedge xgmii_rx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      a_d          <= '0;
      a_c          <= '0;
      b_d          <= '0;
      b_c          <= '0;
      lane_shift   <= '0;
      shift_prev   <= '0;
      mis_pend     <= 1'b0;
      err_misalign <= 1'b0;
      err_drop     <= 1'b0;
      cnt_q        <= '0;
      xgmii_rxd_o  <= '0;
      xgmii_rxc_o  <= '0;
    end else begin
      a_d          <= xgmii_rxd_i;
      a_c          <= xgmii_rxc_i;
      b_d          <= a_d;
      b_c          <= a_c;
      shift_prev   <= lane_shift;
      if (start_found) begin
        lane_shift <= start_lane;
        cnt_q      <= cnt_q + 32'd1;
      end
      mis_pend     <= start_illegal && !start_found;
      err_misalign <= mis_pend;
      err_drop     <= drop_now;
      xgmii_rxd_o  <= fill_d;
      xgmii_rxc_o  <= fill_c;
    end
  end

endmodule

// File: tb/tb_xgmiialign.sv
// Scoreboard bench for xgmiialign. The reference model treats the input as a
// continuous byte stream: each output word starts at stream position
// 8*word + shift, bytes behind the previous output's end are idle-filled and
// bytes skipped over are checked for non-idle content.
module tb_xgmiialign;

  localparam int         ALIGN = 4;
  localparam logic [7:0] START = 8'hFB;
  localparam logic [7:0] IDLE  = 8'h07;
  localparam logic [7:0] TERM  = 8'hFD;

  logic        clk;
  logic        rst;
  logic [63:0] rxd;
  logic [7:0]  rxc;
  logic [63:0] rxd_o;
  logic [7:0]  rxc_o;
  logic [2:0]  lane_shift;
  logic        err_misalign;
  logic        err_drop;
  logic [31:0] start_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic        drop;
    logic        mis;
    logic [2:0]  sh;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  st_d[$];
  logic        st_c[$];
  int          sh_hist[$];
  logic        mis_hist[$];
  int          next_pos;
  logic [31:0] cnt_m;

  xgmiialign dut (
    .xgmii_rx_clk (clk),
    .sys_rst      (rst),
    .xgmii_rxd_i  (rxd),
    .xgmii_rxc_i  (rxc),
    .xgmii_rxd_o  (rxd_o),
    .xgmii_rxc_o  (rxc_o),
    .lane_shift   (lane_shift),
    .err_misalign (err_misalign),
    .err_drop     (err_drop),
    .start_cnt    (start_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Registers hold zeros after reset: two all-zero words precede the stream.
  task automatic model_reset();
    st_d.delete();
    st_c.delete();
    sh_hist.delete();
    mis_hist.delete();
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      st_d.push_back(8'h00);
      st_c.push_back(1'b0);
    end
    sh_hist.push_back(0);
    sh_hist.push_back(0);
    mis_hist.push_back(1'b0);
    mis_hist.push_back(1'b0);
    next_pos = 0;
    cnt_m    = 32'd0;
  endtask

  task automatic model_step(input logic [63:0] d, input logic [7:0] c);
    int   k, base, s_new, np, pos;
    logic legal, ill, drop;
    exp_t e;
    legal = 1'b0;
    ill   = 1'b0;
    np    = 0;
    for (int p = 0; p < 8; p++) begin
      if (c[p] && d[8*p +: 8] == START) begin
        if (p % ALIGN == 0) begin
          if (!legal) begin
            legal = 1'b1;
            np    = p;
          end
        end else begin
          ill = 1'b1;
        end
      end
    end
    s_new = legal ? np : sh_hist[sh_hist.size()-1];
    if (legal) cnt_m = cnt_m + 32'd1;
    for (int p = 0; p < 8; p++) begin
      st_d.push_back(d[8*p +: 8]);
      st_c.push_back(c[p]);
    end
    sh_hist.push_back(s_new);
    mis_hist.push_back(!legal && ill);
    k    = sh_hist.size() - 1;
    base = 8*(k-2) + sh_hist[k-1];
    for (int j = 0; j < 8; j++) begin
      pos = base + j;
      if (pos < next_pos) begin
        e.d[8*j +: 8] = IDLE;
        e.c[j]        = 1'b1;
      end else begin
        e.d[8*j +: 8] = st_d[pos];
        e.c[j]        = st_c[pos];
      end
    end
    drop = 1'b0;
    for (int q = next_pos; q < base; q++)
      if (!(st_c[q] && st_d[q] == IDLE)) drop = 1'b1;
    e.drop   = drop;
    e.mis    = mis_hist[k-1];
    e.sh     = 3'(s_new);
    e.cnt    = cnt_m;
    next_pos = base + 8;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [63:0] d, input logic [7:0] c);
    rxd = d;
    rxc = c;
    model_step(d, c);
    @(negedge clk);
  endtask

  task automatic rand_word(output logic [63:0] d, output logic [7:0] c);
    int kind, a, b, t;
    d    = {$urandom, $urandom};
    c    = 8'h00;
    kind = $urandom_range(0, 9);
    case (kind)
      0, 1, 2: begin d = {8{IDLE}}; c = 8'hFF; end
      3, 4:    c = 8'h00;
      5: begin d[7:0] = START; c = 8'h01; end
      6: begin
        if ($urandom_range(0, 1) == 1) begin d[31:0] = {4{IDLE}}; c[3:0] = 4'hF; end
        d[39:32] = START;
        c[4]     = 1'b1;
      end
      7: begin
        d = {8{IDLE}};
        c = 8'hFF;
        a = $urandom_range(0, 5);
        a = (a < 3) ? a + 1 : a + 2;
        d[8*a +: 8] = START;
      end
      8: begin
        d = {8{IDLE}};
        c = 8'hFF;
        t = $urandom_range(0, 7);
        for (int i = 0; i < t; i++) begin
          d[8*i +: 8] = 8'($urandom);
          c[i]        = 1'b0;
        end
        d[8*t +: 8] = TERM;
      end
      default: begin
        a = $urandom_range(0, 7);
        b = $urandom_range(0, 7);
        d[8*a +: 8] = START;
        d[8*b +: 8] = START;
        c[a] = 1'b1;
        c[b] = 1'b1;
      end
    endcase
  endtask

  // Monitor: one scoreboard entry per output word, sampled after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rxd_o",        rxd_o,                e.d);
        chk("rxc_o",        64'(rxc_o),           64'(e.c));
        chk("err_drop",     64'(err_drop),        64'(e.drop));
        chk("err_misalign", 64'(err_misalign),    64'(e.mis));
        chk("lane_shift",   64'(lane_shift),      64'(e.sh));
        chk("start_cnt",    64'(start_cnt),       64'(e.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] W_IDLE = {8{8'h07}};
  localparam logic [63:0] W_S0   = {8'hD5, {6{8'h55}}, 8'hFB};
  localparam logic [63:0] W_S4   = {{3{8'h55}}, 8'hFB, {4{8'h07}}};
  localparam logic [63:0] W_S2   = {{5{8'h07}}, 8'hFB, {2{8'h07}}};
  localparam logic [63:0] W_TERM = {{7{8'h07}}, 8'hFD};

  initial begin
    logic [63:0] d;
    logic [7:0]  c;
    rst = 1'b1;
    rxd = '0;
    rxc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset rxd_o",        rxd_o,             64'h0);
    chk("reset rxc_o",        64'(rxc_o),        64'h0);
    chk("reset lane_shift",   64'(lane_shift),   64'h0);
    chk("reset err_misalign", 64'(err_misalign), 64'h0);
    chk("reset err_drop",     64'(err_drop),     64'h0);
    chk("reset start_cnt",    64'(start_cnt),    64'h0);
    rst = 1'b0;

    // Lane 0 starts: plain 3-cycle delay.
    repeat (3) begin
      send(W_IDLE, 8'hFF);
      send(W_S0, 8'h01);
      repeat (3) send({$urandom, $urandom}, 8'h00);
      send(W_TERM, 8'hFF);
    end
    // Lane 4 start after idles, then back to lane 0 (4 -> 0 idle fill).
    repeat (3) send(W_IDLE, 8'hFF);
    send(W_S4, 8'h1F);
    repeat (3) send({$urandom, $urandom}, 8'h00);
    send(W_TERM, 8'hFF);
    send(W_IDLE, 8'hFF);
    send(W_S0, 8'h01);
    repeat (2) send({$urandom, $urandom}, 8'h00);
    // Non-idle drop: data word directly before a lane 4 start.
    send({$urandom, $urandom}, 8'h00);
    send(W_S4, 8'h1F);
    repeat (2) send({$urandom, $urandom}, 8'h00);
    send(W_TERM, 8'hFF);
    // Illegal start lane.
    send(W_IDLE, 8'hFF);
    send(W_S2, 8'hFF);
    repeat (3) send(W_IDLE, 8'hFF);

    // Reset mid-frame at shift 4: outputs clear without a clock edge.
    send(W_S4, 8'h1F);
    send({$urandom, $urandom}, 8'h00);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rxd = '0;
    rxc = '0;
    #1;
    chk("async rst rxd_o",        rxd_o,             64'h0);
    chk("async rst rxc_o",        64'(rxc_o),        64'h0);
    chk("async rst lane_shift",   64'(lane_shift),   64'h0);
    chk("async rst err_misalign", 64'(err_misalign), 64'h0);
    chk("async rst err_drop",     64'(err_drop),     64'h0);
    chk("async rst start_cnt",    64'(start_cnt),    64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) send(W_IDLE, 8'hFF);
    send(W_S4, 8'h1F);
    send({$urandom, $urandom}, 8'h00);
    send(W_TERM, 8'hFF);

    // Counter wrap from all-ones.
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    cnt_m = 32'hFFFF_FFFF;
    send(W_S0, 8'h01);
    send(W_S0, 8'h01);
    send(W_IDLE, 8'hFF);

    // Randomised traffic.
    repeat (1500) begin
      rand_word(d, c);
      send(d, c);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
